// File: rtl/spi_master_n_if.sv
// spi_master_n_if: request/response and serial-line bundle for spi_master_n.
// The master modport is the controller's view; slave is the requester/pad side.
interface spi_master_n_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 2
);
  logic              start;
  logic [2:0]        cs_sel;
  logic              polarity;
  logic              phase;
  logic              lsb_first;
  logic [DATA_W-1:0] data_wr;
  logic              miso;
  logic              spi_clk;
  logic              mosi;
  logic [NUM_CS-1:0] cs_n;
  logic [DATA_W-1:0] data_rd;
  logic              busy;
  logic              done;
  logic [1:0]        state;
  logic [5:0]        count;

  modport master (
    input  start, cs_sel, polarity, phase, lsb_first, data_wr, miso,
    output spi_clk, mosi, cs_n, data_rd, busy, done, state, count
  );

  modport slave (
    output start, cs_sel, polarity, phase, lsb_first, data_wr, miso,
    input  spi_clk, mosi, cs_n, data_rd, busy, done, state, count
  );
endinterface

// File: rtl/spi_master_n.sv
// spi_master_n: single-word SPI master with selectable CPOL/CPHA/bit order.
// Optional macro SPI_MASTER_N_LOOPBACK_EN: receive shifter samples the internal
// mosi instead of the miso pin.
//
// state | meaning
// IDLE  | waiting for start; spi_clk tracks polarity input, mosi low
// SETUP | chip select asserted, CLK_DIV cycles before the first edge
// XFER  | 2*DATA_W spi_clk edges, one per CLK_DIV cycles
// HOLD  | chip select still asserted for CLK_DIV cycles
module spi_master_n #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2,
  parameter int NUM_CS  = 2
) (
  input  logic          clk,
  input  logic          reset,
  spi_master_n_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, XFER = 2'd2, HOLD = 2'd3} state_t;

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);

  state_t            st;
  logic [DIV_W-1:0]  div_cnt;
  logic [6:0]        edge_left;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              pol_q, pha_q, lsb_q;
  logic              sclk_q, mosi_q, busy_q, done_q;
  logic [NUM_CS-1:0] cs_q;
  logic [DATA_W-1:0] rd_q;
  logic [5:0]        cnt_q;
  logic              accept, tick, leading, sample_ev, shift_ev, rx_bit;

  function automatic logic pick(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b,
                                                 input logic lsb);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  // Out-of-range chip selects are dropped at the door.
  assign accept    = bus.start && (32'(bus.cs_sel) < NUM_CS);
  // The next edge is a leading one when spi_clk still sits at idle level.
  assign tick      = (st == XFER) && (div_cnt == '0);
  assign leading   = (sclk_q == pol_q);
  assign sample_ev = tick && (leading ^ pha_q);
  assign shift_ev  = tick && !(leading ^ pha_q);

`ifdef SPI_MASTER_N_LOOPBACK_EN
  assign rx_bit = mosi_q;
`else
  assign rx_bit = bus.miso;
`endif

  // Sequencer, shifters and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= IDLE;
      div_cnt   <= '0;
      edge_left <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      pol_q     <= 1'b0;
      pha_q     <= 1'b0;
      lsb_q     <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_q      <= '1;
      rd_q      <= '0;
      cnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (st)
        IDLE: begin
          sclk_q <= bus.polarity;
          mosi_q <= 1'b0;
          if (accept) begin
            st        <= SETUP;
            busy_q    <= 1'b1;
            pol_q     <= bus.polarity;
            pha_q     <= bus.phase;
            lsb_q     <= bus.lsb_first;
            cs_q      <= ~(NUM_CS'(1) << bus.cs_sel);
            div_cnt   <= DIV_RELOAD;
            edge_left <= 7'(2 * DATA_W);
            cnt_q     <= 6'(DATA_W);
            rx_sh     <= '0;
            // CPHA=0 presents the first bit before the first edge.
            if (bus.phase) begin
              tx_sh  <= bus.data_wr;
            end else begin
              tx_sh  <= shift_out(bus.data_wr, bus.lsb_first);
              mosi_q <= pick(bus.data_wr, bus.lsb_first);
            end
          end
        end
        SETUP: begin
          if (div_cnt == '0) begin
            st      <= XFER;
            div_cnt <= DIV_RELOAD;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        XFER: begin
          if (div_cnt == '0) begin
            div_cnt   <= DIV_RELOAD;
            sclk_q    <= ~sclk_q;
            edge_left <= edge_left - 1'b1;
            if (sample_ev) begin
              rx_sh <= shift_in(rx_sh, rx_bit, lsb_q);
              cnt_q <= cnt_q - 1'b1;
            end
            if (shift_ev) begin
              mosi_q <= pick(tx_sh, lsb_q);
              tx_sh  <= shift_out(tx_sh, lsb_q);
            end
            if (edge_left == 7'd1) begin
              st     <= HOLD;
              mosi_q <= 1'b0;
            end
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (div_cnt == '0) begin
            st     <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            cs_q   <= '1;
            rd_q   <= rx_sh;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.spi_clk = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.cs_n    = cs_q;
  assign bus.data_rd = rd_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.state   = st;
  assign bus.count   = cnt_q;
endmodule

// File: tb/tb_spi_master_n.sv
// tb_spi_master_n: directed transfers; expected read words and done timing go
// into a queue, a negedge monitor pops and compares on every done pulse.
module tb_spi_master_n;
  localparam int DATA_W  = 8;
  localparam int CLK_DIV = 2;
  localparam int NUM_CS  = 2;
  localparam int LAT     = 37;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tie = 1'b0;
  logic miso_val = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [DATA_W-1:0] exp_q[$];
  int                stc_q[$];
  logic [DATA_W-1:0] mon_e;
  int                mon_s;

  spi_master_n_if #(.DATA_W(DATA_W), .NUM_CS(NUM_CS)) bus ();

  spi_master_n #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .NUM_CS(NUM_CS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  assign bus.miso = tie ? bus.mosi : miso_val;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every done must match the oldest pending request.
  always @(negedge clk) begin
    if (reset && bus.done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        mon_s = stc_q.pop_front();
        check("data_rd", bus.data_rd, mon_e);
        check("latency", cyc - mon_s, LAT);
      end
    end
  end

  // Call right after a negedge; start is dropped by watch/caller next cycle.
  task automatic issue(input logic [7:0] d, input logic [2:0] cs, input logic pol,
                       input logic pha, input logic lsb, input bit expect_it,
                       input logic [7:0] exp_rd);
    bus.data_wr   = d;
    bus.cs_sel    = cs;
    bus.polarity  = pol;
    bus.phase     = pha;
    bus.lsb_first = lsb;
    bus.start     = 1'b1;
    if (expect_it) begin
      exp_q.push_back(exp_rd);
      stc_q.push_back(cyc);
    end
  endtask

  // Follows one transfer to its done; scrambles inputs after acceptance.
  task automatic watch(input int cs_idx, input logic pol, output int edges,
                       output logic [7:0] cap, output int cs_low, output logic [1:0] cs_seen,
                       output logic [5:0] cnt0, output logic [5:0] cnt_last, output bit got);
    logic prev;
    prev = bus.spi_clk;
    edges = 0; cap = '0; cs_low = 0; cs_seen = '1; cnt0 = '0; cnt_last = '1; got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.start     = 1'b0;
        bus.data_wr   = ~bus.data_wr;
        bus.cs_sel    = bus.cs_sel ^ 3'd1;
        bus.phase     = ~bus.phase;
        bus.lsb_first = ~bus.lsb_first;
        cnt0          = bus.count;
      end
      if (bus.done) begin
        got = 1;
        break;
      end
      if (bus.spi_clk !== prev) begin
        edges++;
        if (prev == pol) cap = {cap[6:0], bus.mosi};
      end
      prev = bus.spi_clk;
      if (!bus.cs_n[cs_idx]) cs_low++;
      if (bus.busy) begin
        cs_seen  = bus.cs_n;
        cnt_last = bus.count;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, cs_low, dn;
    logic [7:0] cap;
    logic [1:0] cs_seen;
    logic [5:0] cnt0, cnt_last;
    bit got, act;

    bus.start = 1'b0; bus.data_wr = '0; bus.cs_sel = '0;
    bus.polarity = 1'b0; bus.phase = 1'b0; bus.lsb_first = 1'b0;

    // Reset values
    #2 reset = 1'b0;
    #10;
    check("rst_state",   bus.state,   2'd0);
    check("rst_spi_clk", bus.spi_clk, 1'b0);
    check("rst_mosi",    bus.mosi,    1'b0);
    check("rst_cs_n",    bus.cs_n,    2'b11);
    check("rst_busy",    bus.busy,    1'b0);
    check("rst_done",    bus.done,    1'b0);
    check("rst_count",   bus.count,   6'd0);
    check("rst_data_rd", bus.data_rd, 8'h00);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 0, 0xAB looped back through miso
    tie = 1'b1;
    issue(8'hAB, 3'd0, 1'b0, 1'b0, 1'b0, 1, 8'hAB);
    watch(0, 1'b0, edges, cap, cs_low, cs_seen, cnt0, cnt_last, got);
    check("t1_done_seen", got, 1);
    check("t1_mosi_bits", cap, 8'hAB);
    check("t1_edges", edges, 16);
    check("t1_count_load", cnt0, 6'd8);
    check("t1_count_end", cnt_last, 6'd0);
    @(negedge clk);
    check("t1_idle_mosi", bus.mosi, 1'b0);
    check("t1_idle_busy", bus.busy, 1'b0);

    // Mode 1, miso held high, 0x00
    tie = 1'b0; miso_val = 1'b1;
    bus.polarity = 1'b0;
    repeat (2) @(negedge clk);
    check("t2_idle_clk", bus.spi_clk, 1'b0);
    issue(8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1, 8'hFF);
    watch(0, 1'b0, edges, cap, cs_low, cs_seen, cnt0, cnt_last, got);
    check("t2_done_seen", got, 1);
    check("t2_edges", edges, 16);
    check("t2_cs0_low_cycles", cs_low, 36);

    // Mode 3, LSB first, slave 1, looped back
    tie = 1'b1;
    bus.polarity = 1'b1;
    repeat (2) @(negedge clk);
    check("t3_idle_clk_pre", bus.spi_clk, 1'b1);
    issue(8'h01, 3'd1, 1'b1, 1'b1, 1'b1, 1, 8'h01);
    watch(1, 1'b1, edges, cap, cs_low, cs_seen, cnt0, cnt_last, got);
    check("t3_done_seen", got, 1);
    check("t3_first_mosi_bit", cap[7], 1'b1);
    check("t3_mosi_bits", cap, 8'h80);
    check("t3_cs_n_xfer", cs_seen, 2'b01);
    check("t3_edges", edges, 16);
    @(negedge clk);
    check("t3_idle_clk_post", bus.spi_clk, 1'b1);

    // Reset after the 4th sampled bit
    bus.polarity = 1'b0;
    repeat (2) @(negedge clk);
    issue(8'hF0, 3'd0, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    act = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.count == 6'd4) begin
        act = 1;
        break;
      end
    end
    check("t4_reached_bit4", act, 1);
    reset = 1'b0;
    #1;
    check("t4_cs_n", bus.cs_n, 2'b11);
    check("t4_busy", bus.busy, 1'b0);
    check("t4_state", bus.state, 2'd0);
    check("t4_data_rd", bus.data_rd, 8'h00);
    @(negedge clk); reset = 1'b1;
    dn = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    check("t4_no_done", dn, 0);
    issue(8'h3C, 3'd0, 1'b0, 1'b0, 1'b0, 1, 8'h3C);
    watch(0, 1'b0, edges, cap, cs_low, cs_seen, cnt0, cnt_last, got);
    check("t4_after_done_seen", got, 1);

    // Start while busy ignored, start in done cycle accepted
    @(negedge clk);
    issue(8'h96, 3'd0, 1'b0, 1'b0, 1'b0, 1, 8'h96);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    issue(8'h11, 3'd1, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    @(negedge clk);
    bus.start = 1'b0;
    act = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done) begin
        act = 1;
        break;
      end
      @(negedge clk);
    end
    check("t5_first_done_seen", act, 1);
    issue(8'hC3, 3'd1, 1'b0, 1'b0, 1'b0, 1, 8'hC3);
    watch(1, 1'b0, edges, cap, cs_low, cs_seen, cnt0, cnt_last, got);
    check("t5_b2b_done_seen", got, 1);
    check("t5_b2b_cs_n", cs_seen, 2'b01);

    // Out-of-range chip select: no activity at all
    @(negedge clk);
    issue(8'h77, 3'd5, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    act = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy || bus.done || (bus.cs_n != 2'b11)) act = 1;
    end
    check("t5_bad_cs_activity", act, 0);

    // miso low, 0x5A: loopback build reads back the tx word
    tie = 1'b0; miso_val = 1'b0;
    issue(8'h5A, 3'd0, 1'b0, 1'b0, 1'b0, 1,
`ifdef SPI_MASTER_N_LOOPBACK_EN
          8'h5A
`else
          8'h00
`endif
    );
    watch(0, 1'b0, edges, cap, cs_low, cs_seen, cnt0, cnt_last, got);
    check("t6_done_seen", got, 1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
